// File: rtl/sixt_pkg.sv
// Shared definitions for the six-tap half-pel path: pixel width default,
// row length limits, feeder state encoding and filter coefficients.
package sixt_pkg;

  localparam int PIX_W_DEF   = 8;
  localparam int ROW_LEN_MIN = 4;
  localparam int ROW_LEN_MAX = 256;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  // Filter taps a..f and rounding offset, used by the downstream datapath.
  localparam int signed TAP_COEF [6] = '{1, -5, 20, 20, -5, 1};
  localparam int        ROUND_C      = 16;
  localparam int        ROUND_SHIFT  = 5;

endpackage

// File: rtl/sixt_tap_feeder_if.sv
// Pixel-in / window-out stream bundle between row fetch, feeder and filter.
interface sixt_tap_feeder_if
  import sixt_pkg::*;
#(
  parameter int PIX_W   = PIX_W_DEF,
  parameter int ROW_LEN = 16
);
  localparam int COL_W = $clog2(ROW_LEN);

  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_pix;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] a, b, c, d, e, f;
  logic [COL_W-1:0] out_col;
  logic             out_last;

  modport master (
    output in_valid, in_pix, out_ready,
    input  in_ready, out_valid, a, b, c, d, e, f, out_col, out_last
  );

  modport slave (
    input  in_valid, in_pix, out_ready,
    output in_ready, out_valid, a, b, c, d, e, f, out_col, out_last
  );
endinterface

// File: rtl/sixt_tap_sreg.sv
// Six-entry pixel shift register; index 0 is tap a (oldest), index 5 is tap f.
module sixt_tap_sreg #(
  parameter int PIX_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  shift,
  input  logic [PIX_W-1:0]      din,
  output logic [5:0][PIX_W-1:0] taps
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      taps <= '0;
    else if (load)
      taps <= {6{din}};
    else if (shift)
      taps <= {din, taps[5:1]};
  end

endmodule

// File: rtl/sixt_tap_feeder.sv
// Turns a pixel row into ROW_LEN border-replicated six-tap windows for the
// half-pel filter, one window per accepted pixel or flush step.
module sixt_tap_feeder
  import sixt_pkg::*;
#(
  parameter int PIX_W   = PIX_W_DEF,
  parameter int ROW_LEN = 16
) (
  input logic               clk,
  input logic               rst_n,
  input logic               clr,
  sixt_tap_feeder_if.slave  bus
);

  localparam int COL_W = $clog2(ROW_LEN);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(ROW_LEN - 1);
  localparam logic [COL_W-1:0] FLUSH_COL = COL_W'(ROW_LEN - 4);

  state_t                state, state_nxt;
  logic [1:0]            fill_cnt, fill_cnt_nxt;
  logic [COL_W-1:0]      col, col_nxt, col_inc;
  logic                  out_valid_q, out_valid_nxt;
  logic                  adv, accept, load, shift;
  logic [PIX_W-1:0]      shift_din;
  logic [5:0][PIX_W-1:0] taps;

  assign adv          = !out_valid_q || bus.out_ready;
  assign bus.in_ready = rst_n && adv && (state != FLUSH);
  assign accept       = bus.in_valid && bus.in_ready;
  assign col_inc      = col + COL_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FILL;
      fill_cnt    <= '0;
      col         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      fill_cnt    <= fill_cnt_nxt;
      col         <= col_nxt;
      out_valid_q <= out_valid_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    fill_cnt_nxt  = fill_cnt;
    col_nxt       = col;
    out_valid_nxt = out_valid_q;
    load          = 1'b0;
    shift         = 1'b0;
    shift_din     = bus.in_pix;
    if (clr) begin
      state_nxt     = FILL;
      fill_cnt_nxt  = '0;
      col_nxt       = '0;
      out_valid_nxt = 1'b0;
    end else begin
      unique case (state)
        FILL: begin
          if (accept) begin
            load  = (fill_cnt == 2'd0);
            shift = (fill_cnt != 2'd0);
            if (fill_cnt == 2'd3) begin
              out_valid_nxt = 1'b1;
              col_nxt       = '0;
              fill_cnt_nxt  = '0;
              // With a 4-pixel row, window 0 is already the last fed window.
              state_nxt     = (ROW_LEN == 4) ? FLUSH : STREAM;
            end else begin
              out_valid_nxt = 1'b0;
              fill_cnt_nxt  = fill_cnt + 2'd1;
            end
          end else if (adv) begin
            out_valid_nxt = 1'b0;
          end
        end
        STREAM: begin
          if (accept) begin
            shift         = 1'b1;
            out_valid_nxt = 1'b1;
            col_nxt       = col_inc;
            if (col_inc == FLUSH_COL)
              state_nxt = FLUSH;
          end else if (adv) begin
            out_valid_nxt = 1'b0;
          end
        end
        FLUSH: begin
          if (adv) begin
            shift         = 1'b1;
            shift_din     = taps[5];
            out_valid_nxt = 1'b1;
            col_nxt       = col_inc;
            if (col_inc == LAST_COL)
              state_nxt = FILL;
          end
        end
        default: state_nxt = FILL;
      endcase
    end
  end

  sixt_tap_sreg #(.PIX_W(PIX_W)) u_sreg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .shift (shift),
    .din   (shift_din),
    .taps  (taps)
  );

  assign bus.out_valid = out_valid_q;
  assign bus.out_col   = col;
  assign bus.out_last  = out_valid_q && (col == LAST_COL);
  assign bus.a = taps[0];
  assign bus.b = taps[1];
  assign bus.c = taps[2];
  assign bus.d = taps[3];
  assign bus.e = taps[4];
  assign bus.f = taps[5];

endmodule
